// File: rtl/tensor_to_bitmap.sv
// rtl/tensor_to_bitmap.sv - quantise a CHW Q0.16 tensor frame and emit it as an HWC 8-bit bitmap
// Optional tlast frame-length checking is enabled by defining TENSOR_TO_BITMAP_LEN_CHECK_EN.
module tensor_to_bitmap #(
   parameter int TDATA_WIDTH = 256,
   parameter int TUSER_WIDTH = 128,
   parameter int IMG_H       = 8,
   parameter int IMG_W       = 8,
   parameter int IMG_C       = 3
) (
   input  logic                     axis_aclk,
   input  logic                     axis_resetn,
   input  logic [TDATA_WIDTH-1:0]   tensor_in_axis_tdata,
   input  logic [TDATA_WIDTH/8-1:0] tensor_in_axis_tkeep,
   input  logic [TUSER_WIDTH-1:0]   tensor_in_axis_tuser,
   input  logic                     tensor_in_axis_tvalid,
   output logic                     tensor_in_axis_tready,
   input  logic                     tensor_in_axis_tlast,
   output logic [TDATA_WIDTH-1:0]   bitmap_out_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0] bitmap_out_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]   bitmap_out_axis_tuser,
   output logic                     bitmap_out_axis_tvalid,
   input  logic                     bitmap_out_axis_tready,
   output logic                     bitmap_out_axis_tlast,
   output logic                     frame_error
);
   localparam int EPB       = TDATA_WIDTH / 16;
   localparam int BPB       = TDATA_WIDTH / 8;
   localparam int HW        = IMG_H * IMG_W;
   localparam int N         = HW * IMG_C;
   localparam int IN_BEATS  = N / EPB;
   localparam int OUT_BEATS = N / BPB;
   localparam int ADDR_W    = $clog2(N);
   localparam int IN_W      = $clog2(IN_BEATS + 1);
   localparam int OUT_W     = $clog2(OUT_BEATS + 1);

`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
   typedef enum logic [1:0] {FILL, DRAIN, DISCARD} state_t;
`else
   typedef enum logic [1:0] {FILL, DRAIN} state_t;
`endif

   state_t                 state;
   logic [IN_W-1:0]        in_cnt;
   logic [OUT_W-1:0]       out_cnt;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic                   out_last_r;
   logic [TUSER_WIDTH-1:0] user_r;
   logic [7:0]             mem [N];
   logic [TDATA_WIDTH-1:0] rd_data;
   logic                   in_hs;

   // Rounded x*255/65536; the 24-bit sum cannot overflow for any 16-bit x.
   function automatic logic [7:0] quantise(input logic [15:0] x);
      logic [23:0] t;
      t = 24'(x) * 24'd255 + 24'd32768;
      return t[23:16];
   endfunction

   function automatic logic [ADDR_W-1:0] hwc_addr(input logic [IN_W-1:0] beat, input int e);
      int i;
      i = int'(beat) * EPB + e;
      return ADDR_W'((i % HW) * IMG_C + i / HW);
   endfunction

   assign in_hs = tensor_in_axis_tvalid && in_ready_r;

   // Transpose happens on the write side so the drain reads contiguous bytes.
   always_ff @(posedge axis_aclk) begin
      if (in_hs && state == FILL) begin
         for (int e = 0; e < EPB; e++)
            mem[hwc_addr(in_cnt, e)] <= quantise(tensor_in_axis_tdata[16*e +: 16]);
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < BPB; k++)
         rd_data[8*k +: 8] = mem[ADDR_W'(int'(out_cnt) * BPB + k)];
   end

   assign tensor_in_axis_tready  = in_ready_r;
   assign bitmap_out_axis_tvalid = out_valid_r;
   assign bitmap_out_axis_tlast  = out_last_r;
   assign bitmap_out_axis_tkeep  = {(TDATA_WIDTH/8){out_valid_r}};
   assign bitmap_out_axis_tdata  = out_valid_r ? rd_data : '0;
   assign bitmap_out_axis_tuser  = user_r;

`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
   logic err_r;
   logic long_r;
   logic unused_inputs;
   assign unused_inputs = ^tensor_in_axis_tkeep;
   assign frame_error   = err_r;
`else
   logic unused_inputs;
   assign unused_inputs = ^{tensor_in_axis_tkeep, tensor_in_axis_tlast};
   assign frame_error   = 1'b0;
`endif

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state       <= FILL;
         in_cnt      <= '0;
         out_cnt     <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         user_r      <= '0;
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
         err_r       <= 1'b0;
         long_r      <= 1'b0;
`endif
      end else begin
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
         err_r <= 1'b0;
`endif
         case (state)
            FILL: begin
               in_ready_r <= 1'b1;
               if (in_hs) begin
                  if (in_cnt == '0)
                     user_r <= tensor_in_axis_tuser;
                  if (in_cnt == IN_W'(IN_BEATS - 1)) begin
                     state       <= DRAIN;
                     in_cnt      <= '0;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                     out_last_r  <= (OUT_BEATS == 1);
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
                     long_r      <= !tensor_in_axis_tlast;
`endif
                  end
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
                  else if (tensor_in_axis_tlast) begin
                     in_cnt <= '0;
                     err_r  <= 1'b1;
                  end
`endif
                  else begin
                     in_cnt <= in_cnt + IN_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (bitmap_out_axis_tready) begin
                  if (out_cnt == OUT_W'(OUT_BEATS - 1)) begin
                     out_cnt     <= '0;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                     in_ready_r  <= 1'b1;
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
                     if (long_r) begin
                        state <= DISCARD;
                        err_r <= 1'b1;
                     end else begin
                        state <= FILL;
                     end
`else
                     state <= FILL;
`endif
                  end else begin
                     out_cnt    <= out_cnt + OUT_W'(1);
                     out_last_r <= (out_cnt == OUT_W'(OUT_BEATS - 2));
                  end
               end
            end
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
            DISCARD: begin
               // Drop the overrun tail of a long frame up to and including its tlast.
               if (in_hs && tensor_in_axis_tlast)
                  state <= FILL;
            end
`endif
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_tensor_to_bitmap.sv
// tb/tb_tensor_to_bitmap.sv - directed self-checking bench for tensor_to_bitmap
module tb_tensor_to_bitmap;
   localparam int TDW = 256, TUW = 128, KW = TDW / 8;
   localparam int H = 8, W = 8, C = 3, N = H * W * C;
   localparam int EPB = TDW / 16, BPB = TDW / 8;
   localparam int IN_BEATS = N / EPB, OUT_BEATS = N / BPB;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [TDW-1:0] in_tdata;
   logic [KW-1:0]  in_tkeep;
   logic [TUW-1:0] in_tuser;
   logic           in_tvalid, in_tready, in_tlast;
   logic [TDW-1:0] out_tdata;
   logic [KW-1:0]  out_tkeep;
   logic [TUW-1:0] out_tuser;
   logic           out_tvalid, out_tready, out_tlast;
   logic           frame_error;

   int vectors = 0;
   int miscompares = 0;
   int err_pulses = 0;
   logic [15:0]    elem  [N];
   logic [7:0]     exp_b [N];
   logic [7:0]     got   [N];
   logic [TUW-1:0] exp_user;

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_error === 1'b1) err_pulses++;

   tensor_to_bitmap dut (
      .axis_aclk(clk), .axis_resetn(rst_n),
      .tensor_in_axis_tdata(in_tdata), .tensor_in_axis_tkeep(in_tkeep),
      .tensor_in_axis_tuser(in_tuser), .tensor_in_axis_tvalid(in_tvalid),
      .tensor_in_axis_tready(in_tready), .tensor_in_axis_tlast(in_tlast),
      .bitmap_out_axis_tdata(out_tdata), .bitmap_out_axis_tkeep(out_tkeep),
      .bitmap_out_axis_tuser(out_tuser), .bitmap_out_axis_tvalid(out_tvalid),
      .bitmap_out_axis_tready(out_tready), .bitmap_out_axis_tlast(out_tlast),
      .frame_error(frame_error)
   );

   function automatic logic [7:0] quant(input logic [15:0] x);
      logic [31:0] t;
      t = 32'(x) * 32'd255 + 32'd32768;
      return t[23:16];
   endfunction

   // Expected HWC byte j comes from CHW element (channel j%C, pixel j/C).
   task automatic build_expected();
      for (int j = 0; j < N; j++) exp_b[j] = quant(elem[(j % C) * H * W + j / C]);
   endtask

   function automatic logic [TDW-1:0] exp_beat(input int b);
      logic [TDW-1:0] d;
      for (int k = 0; k < BPB; k++) d[8*k +: 8] = exp_b[b * BPB + k];
      return d;
   endfunction

   task automatic send_beat(input logic [TDW-1:0] d, input logic [TUW-1:0] u, input logic l);
      int cnt;
      in_tdata = d; in_tuser = u; in_tlast = l; in_tvalid = 1'b1;
      cnt = 0;
      while (in_tready !== 1'b1 && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 300) begin
         vectors++; miscompares++;
         $display("FAIL in_handshake_timeout: tready=%b required 1", in_tready);
      end
      @(negedge clk);
      in_tvalid = 1'b0; in_tlast = 1'b0;
   endtask

   task automatic send_frame(input logic [TUW-1:0] u, input int nbeats, input int last_beat);
      logic [TDW-1:0] d;
      for (int b = 0; b < nbeats; b++) begin
         for (int e = 0; e < EPB; e++)
            d[16*e +: 16] = (b < IN_BEATS) ? elem[b * EPB + e] : 16'hBEEF;
         send_beat(d, (b == 0) ? u : '0, b == last_beat);
      end
   endtask

   task automatic collect(input bit stall, input int max_beats);
      int beat, cyc;
      bit stalled;
      logic [TDW-1:0] prev_d;
      logic [TUW-1:0] prev_u;
      beat = 0; cyc = 0; stalled = 0;
      while (beat < max_beats && cyc < 400) begin
         out_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_tvalid === 1'b1) begin
            vectors++;
            if (in_tready !== 1'b0) begin
               miscompares++;
               $display("FAIL in_tready_during_drain: got %b required 0", in_tready);
            end
            if (stalled) begin
               vectors++;
               if (out_tdata !== prev_d || out_tuser !== prev_u) begin
                  miscompares++;
                  $display("FAIL stall_stable beat %0d: tdata %h tuser %h required %h %h",
                           beat, out_tdata, out_tuser, prev_d, prev_u);
               end
            end
            if (out_tready) begin
               for (int k = 0; k < BPB; k++) got[beat * BPB + k] = out_tdata[8*k +: 8];
               vectors++;
               if (out_tdata !== exp_beat(beat)) begin
                  miscompares++;
                  $display("FAIL tdata beat %0d: got %h required %h", beat, out_tdata, exp_beat(beat));
               end
               vectors++;
               if (out_tlast !== (beat == OUT_BEATS - 1)) begin
                  miscompares++;
                  $display("FAIL tlast beat %0d: got %b required %b", beat, out_tlast, beat == OUT_BEATS - 1);
               end
               vectors++;
               if (out_tkeep !== {KW{1'b1}} || out_tuser !== exp_user) begin
                  miscompares++;
                  $display("FAIL tkeep_tuser beat %0d: got %h %h required all-ones %h",
                           beat, out_tkeep, out_tuser, exp_user);
               end
               beat++;
            end
            stalled = !out_tready;
            prev_d = out_tdata; prev_u = out_tuser;
         end else begin
            stalled = 0;
         end
         @(negedge clk);
         cyc++;
      end
      out_tready = 1'b0;
      if (beat < max_beats) begin
         vectors++; miscompares++;
         $display("FAIL drain_timeout: got %0d beats required %0d", beat, max_beats);
      end
   endtask

   task automatic check_latency(input string name);
      vectors++;
      if (out_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_first_beat_latency: tvalid=%b required 1", name, out_tvalid);
      end
   endtask

   task automatic check_idle(input string name);
      vectors++;
      if (out_tvalid !== 1'b0 || in_tready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_after_drain: tvalid=%b tready=%b required 0 1", name, out_tvalid, in_tready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_tvalid = 0; in_tlast = 0; in_tdata = '0; in_tuser = '0;
      in_tkeep = '1; out_tready = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if (in_tready !== 0 || out_tvalid !== 0 || out_tlast !== 0 || out_tkeep !== '0 ||
          out_tdata !== '0 || out_tuser !== '0 || frame_error !== 0) begin
         miscompares++;
         $display("FAIL reset_outputs: tready=%b tvalid=%b tlast=%b tkeep=%h tuser=%h ferr=%b required all 0",
                  in_tready, out_tvalid, out_tlast, out_tkeep, out_tuser, frame_error);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (in_tready !== 1'b1 || out_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: tready=%b tvalid=%b required 1 0", in_tready, out_tvalid);
      end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < N; i++) elem[i] = 16'(i * 16'h0155);
      build_expected();
      exp_user = 128'h1234;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      check_latency("ramp");
      collect(0, OUT_BEATS);
      check_idle("ramp");
      vectors++;
      if (got[0] !== 8'd0 || got[1] !== 8'd85) begin
         miscompares++;
         $display("FAIL ramp_bytes01: got %0d %0d required 0 85", got[0], got[1]);
      end
   endtask

   task automatic test_quant_corners();
      for (int i = 0; i < N; i++) elem[i] = 16'h0;
      elem[0] = 16'h0000; elem[1] = 16'h0080; elem[2] = 16'h8000; elem[3] = 16'hFFFF;
      build_expected();
      exp_user = 128'h77;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      check_latency("corners");
      collect(0, OUT_BEATS);
      vectors++;
      if (got[0] !== 8'd0 || got[3] !== 8'd0 || got[6] !== 8'd128 || got[9] !== 8'd255) begin
         miscompares++;
         $display("FAIL quant_corners: got %0d %0d %0d %0d required 0 0 128 255",
                  got[0], got[3], got[6], got[9]);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) elem[i] = 16'($urandom);
      build_expected();
      exp_user = {4{32'hC0FFEE01}};
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      check_latency("backpressure");
      collect(1, OUT_BEATS);
      check_idle("backpressure");
   endtask

   task automatic test_tuser_capture();
      for (int i = 0; i < N; i++) elem[i] = 16'(16'hFFFF - i * 16'd300);
      build_expected();
      exp_user = 128'hA5;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      collect(0, OUT_BEATS);
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < N; i++) elem[i] = 16'(i * 16'd97 + 16'd5);
      build_expected();
      exp_user = 128'h3C;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      collect(0, 3);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_tvalid !== 1'b0 || out_tkeep !== '0 || in_tready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_drain: tvalid=%b tkeep=%h tready=%b required 0 0 0",
                  out_tvalid, out_tkeep, in_tready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("post_reset");
      for (int i = 0; i < N; i++) elem[i] = 16'(16'h8000 ^ (i * 16'd211));
      build_expected();
      exp_user = 128'h5A5A;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      check_latency("post_reset");
      collect(0, OUT_BEATS);
      check_idle("post_reset_frame");
   endtask

`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
   task automatic test_short_frame();
      int p0;
      for (int i = 0; i < N; i++) elem[i] = 16'(i * 16'd123);
      p0 = err_pulses;
      send_frame(128'hEE, 5, 4);
      vectors++;
      if (frame_error !== 1'b1 || out_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL short_frame_error: ferr=%b tvalid=%b required 1 0", frame_error, out_tvalid);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (out_tvalid !== 1'b0 || err_pulses - p0 !== 1) begin
         miscompares++;
         $display("FAIL short_frame_no_output: tvalid=%b pulses=%0d required 0 1", out_tvalid, err_pulses - p0);
      end
      build_expected();
      exp_user = 128'h11;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      check_latency("after_short");
      collect(0, OUT_BEATS);
   endtask

   task automatic test_long_frame();
      int p0;
      for (int i = 0; i < N; i++) elem[i] = 16'(i * 16'd77 + 16'd9);
      build_expected();
      exp_user = 128'h22;
      p0 = err_pulses;
      send_frame(exp_user, IN_BEATS, -1);
      check_latency("long");
      collect(0, OUT_BEATS);
      vectors++;
      if (frame_error !== 1'b1 || in_tready !== 1'b1) begin
         miscompares++;
         $display("FAIL long_discard_entry: ferr=%b tready=%b required 1 1", frame_error, in_tready);
      end
      send_beat({8{32'hDEADBEEF}}, '0, 1'b0);
      send_beat({8{32'hDEADBEEF}}, '0, 1'b1);
      repeat (2) @(negedge clk);
      vectors++;
      if (out_tvalid !== 1'b0 || err_pulses - p0 !== 1) begin
         miscompares++;
         $display("FAIL long_discard: tvalid=%b pulses=%0d required 0 1", out_tvalid, err_pulses - p0);
      end
      for (int i = 0; i < N; i++) elem[i] = 16'(16'hFFFF - i * 16'd55);
      build_expected();
      exp_user = 128'h33;
      send_frame(exp_user, IN_BEATS, IN_BEATS - 1);
      check_latency("after_long");
      collect(0, OUT_BEATS);
   endtask
`endif

   task automatic test_no_spurious_error(input int expected);
      vectors++;
      if (err_pulses !== expected) begin
         miscompares++;
         $display("FAIL frame_error_count: got %0d required %0d", err_pulses, expected);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_quant_corners();
      test_backpressure();
      test_tuser_capture();
      test_reset_mid_drain();
      test_no_spurious_error(0);
`ifdef TENSOR_TO_BITMAP_LEN_CHECK_EN
      test_short_frame();
      test_long_frame();
      test_no_spurious_error(2);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
